// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and constants for the button debounce front end
// Contents: debounce FSM state encoding, legal range of the STABLE_CYCLES parameter.

package btn_pkg;

   // Gray-style encoding: each legal transition flips a single state bit.
   typedef enum logic [1:0] {
      S_LOW       = 2'b00,
      S_WAIT_HIGH = 2'b01,
      S_HIGH      = 2'b11,
      S_WAIT_LOW  = 2'b10
   } btn_state_t;

   localparam int STABLE_CYCLES_MIN = 2;
   localparam int STABLE_CYCLES_MAX = 65535;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a single asynchronous level
// Ports:
//   clk   in  1  sampling clock, rising edge
//   rst   in  1  synchronous active-high reset, both flops clear to 0
//   raw   in  1  asynchronous input level
//   sync  out 1  input level retimed into the clk domain, two edges late

module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic sync
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

endmodule

// File: rtl/btn_debounce_edge.sv
// rtl/btn_debounce_edge.sv - debounced level plus single-cycle edge pulses for a push-button input
// Optional feature macro: BTN_DEBOUNCE_FALL_EN adds the FALL port and its pulse register.
// Ports:
//   CLK     in  1  system clock, rising edge
//   RST     in  1  synchronous active-high reset
//   BTN_IN  in  1  raw asynchronous button/switch level
//   LEVEL   out 1  debounced level
//   RISE    out 1  one-cycle pulse on an accepted 0->1 change
//   FALL    out 1  one-cycle pulse on an accepted 1->0 change (BTN_DEBOUNCE_FALL_EN only)
//   BUSY    out 1  high while a candidate change is being qualified
// Parameter:
//   STABLE_CYCLES  consecutive synchronised samples needed to accept a change (2..65535)

module btn_debounce_edge
   import btn_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_IN,
   output logic LEVEL,
   output logic RISE,
`ifdef BTN_DEBOUNCE_FALL_EN
   output logic FALL,
`endif
   output logic BUSY
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (STABLE_CYCLES < STABLE_CYCLES_MIN || STABLE_CYCLES > STABLE_CYCLES_MAX) begin : g_bad_param
      $error("btn_debounce_edge: STABLE_CYCLES out of range");
   end

   logic             sync;
   btn_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             level_nx;
   logic             rise_nx;
`ifdef BTN_DEBOUNCE_FALL_EN
   logic             fall_nx;
`endif

   sync2 u_sync (
      .clk  (CLK),
      .rst  (RST),
      .raw  (BTN_IN),
      .sync (sync)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_LOW;
         cnt   <= '0;
         LEVEL <= 1'b0;
         RISE  <= 1'b0;
`ifdef BTN_DEBOUNCE_FALL_EN
         FALL  <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         LEVEL <= level_nx;
         RISE  <= rise_nx;
`ifdef BTN_DEBOUNCE_FALL_EN
         FALL  <= fall_nx;
`endif
      end
   end

   // The first sample of a new value already counts, so a waiting state is
   // entered with cnt=1 and acceptance happens on the STABLE_CYCLES-th sample.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      level_nx = LEVEL;
      rise_nx  = 1'b0;
`ifdef BTN_DEBOUNCE_FALL_EN
      fall_nx  = 1'b0;
`endif
      case (state)
         S_LOW: begin
            if (sync) begin
               state_nx = S_WAIT_HIGH;
               cnt_nx   = CNT_ONE;
            end
         end
         S_WAIT_HIGH: begin
            if (!sync) begin
               state_nx = S_LOW;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = S_HIGH;
               cnt_nx   = '0;
               level_nx = 1'b1;
               rise_nx  = 1'b1;
            end else begin
               cnt_nx   = cnt + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (!sync) begin
               state_nx = S_WAIT_LOW;
               cnt_nx   = CNT_ONE;
            end
         end
         S_WAIT_LOW: begin
            if (sync) begin
               state_nx = S_HIGH;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = S_LOW;
               cnt_nx   = '0;
               level_nx = 1'b0;
`ifdef BTN_DEBOUNCE_FALL_EN
               fall_nx  = 1'b1;
`endif
            end else begin
               cnt_nx   = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nx = S_LOW;
            cnt_nx   = '0;
         end
      endcase
   end

   assign BUSY = (state == S_WAIT_HIGH) || (state == S_WAIT_LOW);

endmodule
